fetch_pc_gen: RTL

Instruction-fetch PC generator and request controller for the IF stage. It holds the architectural fetch PC, issues index requests to the instruction cache and MMU, and selects the next PC from exception redirects, branch redirects or the sequential 8-byte fetch block. Every accepted fetch is tagged one cycle later with its PC, validity and misalignment exception, so the tag is in the same cycle as the registered MMU translation.

---
 rtl/fetch_pc_gen_if.sv | 33 +++
 rtl/fetch_pc_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle between the PC generator, the I-cache/MMU index port,
// the redirect sources and the stage-2 fetch tag consumers.
interface fetch_pc_gen_if;
    logic        stall_i;
    logic        exc_redirect_i;
    logic [31:0] exc_pc_i;
    logic        br_redirect_i;
    logic [31:0] br_pc_i;
    logic        inst_req_o;
    logic        inst_index_ok_i;
    logic [31:0] PCR_VAddr_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_pc_o;
    logic        FCT_hasException_o;
    logic [4:0]  FCT_ExcCode_o;
    logic [31:0] FCT_badVAddr_o;

    modport master (
        input  stall_i, exc_redirect_i, exc_pc_i, br_redirect_i, br_pc_i,
        input  inst_index_ok_i,
        output inst_req_o, PCR_VAddr_o,
        output fetch_valid_o, fetch_pc_o,
        output FCT_hasException_o, FCT_ExcCode_o, FCT_badVAddr_o
    );

    modport slave (
        output stall_i, exc_redirect_i, exc_pc_i, br_redirect_i, br_pc_i,
        output inst_index_ok_i,
        input  inst_req_o, PCR_VAddr_o,
        input  fetch_valid_o, fetch_pc_o,
        input  FCT_hasException_o, FCT_ExcCode_o, FCT_badVAddr_o
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// IF-stage PC generator: issues index requests, picks the next PC from
// exception/branch redirects or the sequential block, tags accepted fetches.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'hbfc00000,
    parameter int unsigned FETCH_BYTES = 8
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_gen_if.master bus
);

    localparam logic [31:0] FETCH_INC  = 32'(FETCH_BYTES);
    localparam logic [31:0] BLOCK_MASK = ~(FETCH_INC - 32'd1);
    localparam logic [4:0]  EXC_ADEL   = 5'h04;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_exc_q, pend_exc_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         has_exc_q, has_exc_d;
    logic [4:0]   exc_code_q, exc_code_d;
    logic [31:0]  bad_vaddr_q, bad_vaddr_d;

    logic         inst_req;
    logic         accept;
    logic         redirect;
    logic         cancel;
    logic         misaligned;
    logic [31:0]  redirect_pc;
    logic [31:0]  seq_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= 32'd0;
            pend_exc_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            has_exc_q     <= 1'b0;
            exc_code_q    <= 5'd0;
            bad_vaddr_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            pend_exc_q    <= pend_exc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            has_exc_q     <= has_exc_d;
            exc_code_q    <= exc_code_d;
            bad_vaddr_q   <= bad_vaddr_d;
        end
    end

    // Gating with rst keeps the request low during reset even before the
    // first reset edge has cleared the state register.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        pend_exc_d    = pend_exc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        has_exc_d     = has_exc_q;
        exc_code_d    = exc_code_q;
        bad_vaddr_d   = bad_vaddr_q;

        inst_req    = rst && ((state_q == WAIT) || ((state_q == RUN) && !bus.stall_i));
        accept      = inst_req && bus.inst_index_ok_i;
        redirect    = bus.exc_redirect_i || bus.br_redirect_i;
        redirect_pc = bus.exc_redirect_i ? bus.exc_pc_i : bus.br_pc_i;
        cancel      = redirect || pend_valid_q;
        misaligned  = (pc_q[1:0] != 2'b00);
        seq_pc      = (pc_q & BLOCK_MASK) + FETCH_INC;

        if (accept) begin
            fetch_valid_d = !cancel;
            fetch_pc_d    = pc_q;
            has_exc_d     = misaligned;
            exc_code_d    = misaligned ? EXC_ADEL : 5'd0;
            bad_vaddr_d   = pc_q;
            pend_valid_d  = 1'b0;
            if (redirect) begin
                pc_d = redirect_pc;
            end else if (pend_valid_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = seq_pc;
            end
            state_d = (misaligned && !cancel) ? HALT : RUN;
        end else if (state_q == WAIT) begin
            // Address must hold while outstanding; a pending exception is
            // never displaced by a later branch.
            if (bus.exc_redirect_i) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = bus.exc_pc_i;
                pend_exc_d   = 1'b1;
            end else if (bus.br_redirect_i && !(pend_valid_q && pend_exc_q)) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = bus.br_pc_i;
                pend_exc_d   = 1'b0;
            end
        end else if (redirect) begin
            pc_d    = redirect_pc;
            state_d = RUN;
        end else if (inst_req) begin
            state_d = WAIT;
        end
    end

    assign bus.inst_req_o         = inst_req;
    assign bus.PCR_VAddr_o        = pc_q;
    assign bus.fetch_valid_o      = fetch_valid_q;
    assign bus.fetch_pc_o         = fetch_pc_q;
    assign bus.FCT_hasException_o = has_exc_q;
    assign bus.FCT_ExcCode_o      = exc_code_q;
    assign bus.FCT_badVAddr_o     = bad_vaddr_q;

endmodule
